// File: rtl/dpd_feature_buffer_if.sv
// rtl/dpd_feature_buffer_if.sv - sample stream and feature-vector handshake bundle for dpd_feature_buffer
//  in_i, in_q      W-bit signed Q1.15 I/Q sample
//  in_valid        sample valid (producer)
//  in_ready        buffer accepts a sample this cycle (buffer)
//  flush           synchronous stream restart (producer)
//  out_vector      W*OUTPUT_DIM assembled feature vector (buffer)
//  out_valid       out_vector valid (buffer)
//  out_ready       consumer accepts out_vector (consumer)
//  master: stimulus/consumer side, slave: the feature buffer

interface dpd_feature_buffer_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 5
);
    localparam int OUTPUT_DIM = 5 * MEMORY_DEPTH + 5;

    logic [DATA_WIDTH-1:0]            in_i;
    logic [DATA_WIDTH-1:0]            in_q;
    logic                             in_valid;
    logic                             in_ready;
    logic                             flush;
    logic [DATA_WIDTH*OUTPUT_DIM-1:0] out_vector;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        output in_i, in_q, in_valid, flush, out_ready,
        input  in_ready, out_vector, out_valid
    );

    modport slave (
        input  in_i, in_q, in_valid, flush, out_ready,
        output in_ready, out_vector, out_valid
    );
endinterface

// File: rtl/dpd_feature_buffer.sv
// rtl/dpd_feature_buffer.sv - GAN-DPD feature pipeline (|x|, |x|^2, |x|^4) with (M+1)-tap memory vector
//  clk     rising-edge clock
//  rst_n   asynchronous active-low reset
//  bus     dpd_feature_buffer_if.slave: in_i/in_q/in_valid/in_ready, flush,
//          out_vector/out_valid/out_ready
//  Optional macro FEAT_AMBM_EN: envelope = alpha-max-beta-min (max + 3/8 min)
//  instead of max(|I|,|Q|). Latency and vector layout are the same in both builds.

module dpd_feature_buffer #(
    parameter int DATA_WIDTH   = 16,
    parameter int MEMORY_DEPTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dpd_feature_buffer_if.slave     bus
);
    localparam int W          = DATA_WIDTH;
    localparam int M          = MEMORY_DEPTH;
    localparam int TAPS       = M + 1;
    localparam int OUTPUT_DIM = 5 * M + 5;
    localparam int CW         = $clog2(TAPS + 1);
    localparam logic [W-1:0]  POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  NEG_MIN = {1'b1, {(W-1){1'b0}}};

    // Magnitude of a two's-complement value; -1.0 has no positive twin so it clips.
    function automatic logic [W-1:0] abs_sat(input logic [W-1:0] x);
        if (x == NEG_MIN)
            return POS_MAX;
        else if (x[W-1])
            return W'(~x + 1'b1);
        else
            return x;
    endfunction

    // Q1.15 square of a non-negative value, truncated back to Q1.15.
    function automatic logic [W-1:0] q15_sq(input logic [W-1:0] a);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, a};
        return p[2*W-2:W-1];
    endfunction

    // Handshake
    logic out_valid_r;
    logic adv;
    logic in_ready;
    logic accept;

    assign adv          = !out_valid_r || bus.out_ready;
    assign in_ready     = adv && !bus.flush;
    assign accept       = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid_r;

    // P1 combinational envelope of the incoming sample
    logic [W-1:0] abs_i, abs_q, env_max, env_in;
`ifdef FEAT_AMBM_EN
    logic [W-1:0] env_min;
    logic [W:0]   ambm;
`endif

    always_comb begin
        abs_i   = abs_sat(bus.in_i);
        abs_q   = abs_sat(bus.in_q);
        env_max = (abs_i > abs_q) ? abs_i : abs_q;
`ifdef FEAT_AMBM_EN
        env_min = (abs_i > abs_q) ? abs_q : abs_i;
        // One extra bit so max + 0.375*min cannot wrap before the clip.
        ambm    = {1'b0, env_max} + {3'b000, env_min[W-1:2]} + {4'b0000, env_min[W-1:3]};
        env_in  = (ambm > {1'b0, POS_MAX}) ? POS_MAX : ambm[W-1:0];
`else
        env_in  = env_max;
`endif
    end

    // Pipeline registers
    logic         p1_valid, p2_valid, p3_valid;
    logic [W-1:0] p1_i, p1_q, p1_env;
    logic [W-1:0] p2_i, p2_q, p2_env, p2_sq;
    logic [W-1:0] p3_i, p3_q, p3_env, p3_sq, p3_p4;

    // Tap history, index 0 = newest sample n
    logic [W-1:0] tap_i   [TAPS];
    logic [W-1:0] tap_q   [TAPS];
    logic [W-1:0] tap_env [TAPS];
    logic [W-1:0] tap_sq  [TAPS];
    logic [W-1:0] tap_p4  [TAPS];
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] fill_inc;

    assign fill_inc = (fill_cnt == CW'(TAPS)) ? fill_cnt : fill_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid    <= 1'b0;
            p2_valid    <= 1'b0;
            p3_valid    <= 1'b0;
            out_valid_r <= 1'b0;
            fill_cnt    <= '0;
            p1_i <= '0; p1_q <= '0; p1_env <= '0;
            p2_i <= '0; p2_q <= '0; p2_env <= '0; p2_sq <= '0;
            p3_i <= '0; p3_q <= '0; p3_env <= '0; p3_sq <= '0; p3_p4 <= '0;
            for (int t = 0; t < TAPS; t++) begin
                tap_i[t]   <= '0;
                tap_q[t]   <= '0;
                tap_env[t] <= '0;
                tap_sq[t]  <= '0;
                tap_p4[t]  <= '0;
            end
        end else if (bus.flush) begin
            // Flush wins over out_ready: a pending vector is dropped, not delivered.
            p1_valid    <= 1'b0;
            p2_valid    <= 1'b0;
            p3_valid    <= 1'b0;
            out_valid_r <= 1'b0;
            fill_cnt    <= '0;
            for (int t = 0; t < TAPS; t++) begin
                tap_i[t]   <= '0;
                tap_q[t]   <= '0;
                tap_env[t] <= '0;
                tap_sq[t]  <= '0;
                tap_p4[t]  <= '0;
            end
        end else if (adv) begin
            p1_valid <= accept;
            p1_i     <= bus.in_i;
            p1_q     <= bus.in_q;
            p1_env   <= env_in;

            p2_valid <= p1_valid;
            p2_i     <= p1_i;
            p2_q     <= p1_q;
            p2_env   <= p1_env;
            p2_sq    <= q15_sq(p1_env);

            p3_valid <= p2_valid;
            p3_i     <= p2_i;
            p3_q     <= p2_q;
            p3_env   <= p2_env;
            p3_sq    <= p2_sq;
            p3_p4    <= q15_sq(p2_sq);

            // Bubbles leave the history alone and only drop out_valid.
            out_valid_r <= p3_valid && (fill_inc == CW'(TAPS));
            if (p3_valid) begin
                fill_cnt <= fill_inc;
                for (int t = TAPS - 1; t > 0; t--) begin
                    tap_i[t]   <= tap_i[t-1];
                    tap_q[t]   <= tap_q[t-1];
                    tap_env[t] <= tap_env[t-1];
                    tap_sq[t]  <= tap_sq[t-1];
                    tap_p4[t]  <= tap_p4[t-1];
                end
                tap_i[0]   <= p3_i;
                tap_q[0]   <= p3_q;
                tap_env[0] <= p3_env;
                tap_sq[0]  <= p3_sq;
                tap_p4[0]  <= p3_p4;
            end
        end
    end

    // Vector assembly straight from the history, so it holds whenever the history holds.
    always_comb begin
        bus.out_vector = '0;
        bus.out_vector[W*0 +: W] = tap_i[0];
        bus.out_vector[W*1 +: W] = tap_q[0];
        for (int g = 0; g < TAPS; g++) begin
            bus.out_vector[W*(2+3*g) +: W] = tap_env[g];
            bus.out_vector[W*(3+3*g) +: W] = tap_sq[g];
            bus.out_vector[W*(4+3*g) +: W] = tap_p4[g];
        end
        for (int g = 1; g < TAPS; g++) begin
            bus.out_vector[W*(2+3*TAPS+2*(g-1))   +: W] = tap_i[g];
            bus.out_vector[W*(2+3*TAPS+2*(g-1)+1) +: W] = tap_q[g];
        end
    end

endmodule

// File: tb/tb_dpd_feature_buffer.sv
// tb/tb_dpd_feature_buffer.sv - scoreboard bench for dpd_feature_buffer

module tb_dpd_feature_buffer;
    localparam int W  = 16;
    localparam int M  = 5;
    localparam int OD = 5 * M + 5;
    localparam int VW = W * OD;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   ready_mode;
    int   last_acc_cyc;

    logic [31:0]   hist[$];
    logic [VW-1:0] exp_q[$];
    logic          prev_stall;
    logic [VW-1:0] prev_vec;

    dpd_feature_buffer_if #(.DATA_WIDTH(W), .MEMORY_DEPTH(M)) bus ();

    dpd_feature_buffer #(.DATA_WIDTH(W), .MEMORY_DEPTH(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int mag(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    function automatic int env_of(input logic [15:0] i, input logic [15:0] q);
        int a, b, mx, mn, e;
        a  = mag(i);
        b  = mag(q);
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
`ifdef FEAT_AMBM_EN
        e = mx + mn / 4 + mn / 8;
        if (e > 32767) e = 32767;
`else
        e = mx;
`endif
        return e;
    endfunction

    function automatic int sq_of(input int v);
        return (v * v) / 32768;
    endfunction

    function automatic logic [VW-1:0] build_vec();
        logic [VW-1:0] v;
        logic [31:0]   s;
        int n, e, sq;
        v = '0;
        n = hist.size() - 1;
        for (int g = 0; g <= M; g++) begin
            s  = hist[n-g];
            e  = env_of(s[31:16], s[15:0]);
            sq = sq_of(e);
            v[W*(2+3*g) +: W] = 16'(e);
            v[W*(3+3*g) +: W] = 16'(sq);
            v[W*(4+3*g) +: W] = 16'(sq_of(sq));
            if (g == 0) begin
                v[0 +: W] = s[31:16];
                v[W +: W] = s[15:0];
            end else begin
                v[W*(2+3*(M+1)+2*(g-1))   +: W] = s[31:16];
                v[W*(2+3*(M+1)+2*(g-1)+1) +: W] = s[15:0];
            end
        end
        return v;
    endfunction

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- input monitor: model + expected push ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            hist.delete();
            exp_q.delete();
        end else begin
            check16("in_ready", {15'd0, bus.in_ready},
                    {15'd0, (!bus.out_valid || bus.out_ready) && !bus.flush});
            if (bus.flush) begin
                hist.delete();
                exp_q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                hist.push_back({bus.in_i, bus.in_q});
                if (hist.size() > M + 1) void'(hist.pop_front());
                if (hist.size() == M + 1) exp_q.push_back(build_vec());
            end
        end
    end

    // ---------------- output monitor: pop + compare, stall stability ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_vec("stall_vector_hold", bus.out_vector, prev_vec);
                check16("stall_valid_hold", {15'd0, bus.out_valid}, 16'd1);
            end
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL vector: got unexpected vector %h expected none", bus.out_vector);
                end else begin
                    check_vec("vector", bus.out_vector, exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
            prev_vec   = bus.out_vector;
        end
    end

    // ---------------- consumer ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] i, input logic [15:0] q);
        bit acc;
        int budget;
        bus.in_i     = i;
        bus.in_q     = q;
        bus.in_valid = 1'b1;
        acc    = 1'b0;
        budget = 0;
        while (!acc && budget < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) last_acc_cyc = cyc;
            @(posedge clk);
            #1;
            budget++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
        end
    endtask

    task automatic do_flush();
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_i     = 16'($urandom);
        bus.in_q     = 16'($urandom);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check16("flush_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check_vec("flush_vector_zero", bus.out_vector, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string nm);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!bus.out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got out_valid=0 expected out_valid=1 within 50 cycles", nm);
        end
    endtask

    function automatic logic [15:0] rand_sample();
        logic [15:0] sp [6];
        sp[0] = 16'h8000; sp[1] = 16'h7FFF; sp[2] = 16'h4000;
        sp[3] = 16'h2000; sp[4] = 16'h0000; sp[5] = 16'hC000;
        if ($urandom_range(3) == 0) return sp[$urandom_range(5)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [15:0] vi;
        cyc          = 0;
        n_checks     = 0;
        n_fail       = 0;
        ready_mode   = 0;
        last_acc_cyc = 0;
        prev_stall   = 1'b0;
        prev_vec     = '0;
        bus.in_i     = '0;
        bus.in_q     = '0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        rst_n        = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check16("reset_out_valid", {15'd0, bus.out_valid}, 16'd0);
        check_vec("reset_vector", bus.out_vector, '0);
        rst_n = 1'b1;
        #1;
        check16("reset_in_ready", {15'd0, bus.in_ready}, 16'd1);
        @(posedge clk);
        #1;

        // Fill: I = 0x0100*k, Q = -I, back-to-back
        for (int k = 1; k <= 6; k++) begin
            vi = 16'(16'h0100 * k);
            send(vi, 16'(-vi));
        end
        wait_out_valid("fill_wait");
        check16("fill_latency", 16'(cyc - last_acc_cyc), 16'd4);
        check16("fill_elem0", bus.out_vector[W*0 +: W], 16'h0600);
        check16("fill_elem20", bus.out_vector[W*20 +: W], 16'h0500);
        check16("fill_elem28", bus.out_vector[W*28 +: W], 16'h0100);
        @(posedge clk);
        #1;

        // Arithmetic / AMBM with the vector held by backpressure
        do_flush();
        ready_mode = 2;
        send(16'h1111, 16'h2222);
        send(16'hF000, 16'h0100);
        send(16'h0123, 16'hFEDC);
        send(16'h4000, 16'h0000);
        send(16'h8000, 16'h0000);
        send(16'h4000, 16'h2000);
        wait_out_valid("arith_wait");
`ifdef FEAT_AMBM_EN
        check16("ambm_env", bus.out_vector[W*2 +: W], 16'h4C00);
`else
        check16("ambm_env", bus.out_vector[W*2 +: W], 16'h4000);
`endif
        check16("sat_env", bus.out_vector[W*5 +: W], 16'h7FFF);
        check16("sat_sq",  bus.out_vector[W*6 +: W], 16'h7FFE);
        check16("sat_p4",  bus.out_vector[W*7 +: W], 16'h7FFC);
        check16("half_env", bus.out_vector[W*8 +: W], 16'h4000);
        check16("half_sq",  bus.out_vector[W*9 +: W], 16'h2000);
        check16("half_p4",  bus.out_vector[W*10 +: W], 16'h0800);

        // Backpressure: 10 cycles of out_ready=0 with a sample offered
        @(posedge clk);
        #1;
        bus.in_i     = 16'h0AAA;
        bus.in_q     = 16'h0555;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check16("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        send(16'h0AAA, 16'h0555);
        for (int k = 0; k < 8; k++) send(rand_sample(), rand_sample());

        // Randomized stream with gaps, random backpressure, flushes and one mid-stream reset
        ready_mode = 1;
        for (int s = 0; s < 300; s++) begin
            if (s == 150) begin
                bus.in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check16("midreset_out_valid", {15'd0, bus.out_valid}, 16'd0);
                check_vec("midreset_vector", bus.out_vector, '0);
                @(posedge clk);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                #1;
                check16("midreset_in_ready", {15'd0, bus.in_ready}, 16'd1);
                @(posedge clk);
                #1;
            end
            if ($urandom_range(39) == 0) do_flush();
            repeat ($urandom_range(2)) begin
                @(posedge clk);
                #1;
            end
            send(rand_sample(), rand_sample());
        end

        // Drain
        ready_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        check16("drain_empty", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
